lab_host_link: RTL
==================

LAB_HOST_LINK -- requirements
Module: lab_host_link

Interface
REQ-001 The block SHALL have parameter baud, default 9600, meaning UART bit rate.
REQ-002 The block SHALL have parameter clock, default 50000000, meaning i_CLK frequency in Hz.
REQ-003 The block SHALL have port i_CLK, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have port i_RST, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_RX, input, 1 bit: serial status stream from the board side.
REQ-006 The block SHALL have port o_TX, output, 1 bit: serial command stream to the board side.
REQ-007 The block SHALL have port i_SWITCH, input, 10 bits: switch state to send.
REQ-008 The block SHALL have port i_BUTTON, input, 4 bits: button state to send.
REQ-009 The block SHALL have port i_SEND, input, 1 bit: transmit request pulse.
REQ-010 The block SHALL have port o_BUSY, output, 1 bit: high while a command frame is being sent.
REQ-011 The block SHALL have port o_LEDS, output, 10 bits: decoded LED state.
REQ-012 The block SHALL have ports o_7S0 through o_7S5, output, 7 bits each: decoded seven-segment patterns, active-low.
REQ-013 The block SHALL have port o_VALID, output, 1 bit: one-cycle pulse when a status frame is accepted.
REQ-014 The block SHALL have port o_ERR, output, 1 bit: one-cycle pulse on an RX stop-bit error.

Function
REQ-015 The bit period SHALL be BIT = clock/baud cycles (integer division); line format is 8N1, LSB first, idle high.
REQ-016 The command frame SHALL be 3 bytes, sent back to back with no idle gap: 0xA5, SW[7:0], {KEY[3:0],2'b00,SW[9:8]}.
REQ-017 i_SEND SHALL be accepted only in a cycle where o_BUSY=0; i_SWITCH and i_BUTTON are snapshotted in that cycle.
REQ-018 o_BUSY SHALL rise the cycle after acceptance and fall the cycle after the last stop bit of byte 3 completes.
REQ-019 i_SEND while o_BUSY=1 SHALL be ignored and not queued.
REQ-020 The TX FSM SHALL use states IDLE, START, DATA(8 bits), STOP, then advance the byte index 0..2 and return to IDLE after byte 2.
REQ-021 i_RX SHALL pass through a 2-flop synchronizer before use.
REQ-022 RX SHALL detect start on a synchronized falling edge and re-check the line low at BIT/2.
- A high line at that check is a false start: return to idle, no error.
REQ-023 RX SHALL sample data at bit centres and check the stop bit at its centre.
- A low stop bit discards the byte, pulses o_ERR, and returns the frame parser to HUNT.
REQ-024 The status frame SHALL be 9 bytes: 0x5A, LEDR[7:0], {6'b0,LEDR[9:8]}, then {1'b0,HEXn[6:0]} for n=0..5.
- Pad bits are ignored.
REQ-025 The parser SHALL use states HUNT and BODY(index 1..8). In HUNT, any byte other than 0x5A is silently discarded.
REQ-026 The parser SHALL collect frame contents into shadow registers. o_LEDS and o_7S0..o_7S5 all update together, with o_VALID=1, in the cycle after byte 8's stop bit is sampled high.
REQ-027 An incomplete frame SHALL leave all decoded outputs unchanged.
REQ-028 TX and RX SHALL operate independently and concurrently.

Reset
REQ-029 While i_RST=0 at a clock edge, the block SHALL set:
- o_TX=1, o_BUSY=0, o_VALID=0, o_ERR=0
- o_LEDS=0, o_7S0..o_7S5=7'h7F
- both FSMs idle, parser in HUNT, counters zero
REQ-030 Reset mid-frame SHALL abort it: TX returns to idle-high at once, a partial RX frame is discarded, and no o_VALID or o_ERR is produced.

Configuration
REQ-031 When macro LAB_HOST_LINK_AUTOSEND_EN is defined, the block SHALL also raise an internal send request whenever {i_BUTTON,i_SWITCH} differs from the last transmitted snapshot while o_BUSY=0.
- A change during busy is sent after the current frame ends.
REQ-032 Without LAB_HOST_LINK_AUTOSEND_EN, frames SHALL be sent only on i_SEND.

Verification (clock=1000000, baud=100000, BIT=10)
REQ-033 Send: i_SWITCH=10'h3C5, i_BUTTON=4'h9, i_SEND pulse -> o_TX carries bytes A5, C5, 93 with 10-cycle bits; o_BUSY high for exactly 300 cycles.
REQ-034 Receive: RX frame 5A,FF,03,40,79,24,30,19,12 -> single o_VALID pulse; o_LEDS=3FF, o_7S0=40, o_7S1=79, o_7S2=24, o_7S3=30, o_7S4=19, o_7S5=12.
REQ-035 Resync: bytes 00,13 then a valid frame -> leading bytes ignored, exactly one o_VALID, no o_ERR.
REQ-036 Framing error: stop bit of byte 4 held low -> o_ERR pulse, outputs unchanged, and the next full frame is accepted.
REQ-037 Reset mid-operation: i_RST=0 during TX byte 2 and RX byte 5 -> o_TX=1, o_BUSY=0, no o_VALID, and the next frames work.
REQ-038 AUTOSEND_EN defined: i_SWITCH toggles bit 0 with no i_SEND -> one frame sent; a second change while busy -> a second frame starts right after the first.

Source files
------------

// File: rtl/lab_host_link.sv
// Host link: sends 0xA5 switch/button command frames on o_TX and decodes 0x5A status frames from i_RX.
// Build option LAB_HOST_LINK_AUTOSEND_EN: also transmit whenever {i_BUTTON,i_SWITCH} changes.
module lab_host_link #(
  parameter int baud  = 9600,
  parameter int clock = 50000000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_RX,
  output logic       o_TX,
  input  logic [9:0] i_SWITCH,
  input  logic [3:0] i_BUTTON,
  input  logic       i_SEND,
  output logic       o_BUSY,
  output logic [9:0] o_LEDS,
  output logic [6:0] o_7S0,
  output logic [6:0] o_7S1,
  output logic [6:0] o_7S2,
  output logic [6:0] o_7S3,
  output logic [6:0] o_7S4,
  output logic [6:0] o_7S5,
  output logic       o_VALID,
  output logic       o_ERR
);
  localparam int BIT = clock / baud;
  localparam int CW  = $clog2(BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT / 2 - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [1:0]      tx_byte_q, tx_byte_d;
  logic [13:0]     snap_q, snap_d;
  logic [7:0]      tx_data;
  logic            tx_tick, send_req;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_tick, byte_ok, byte_bad;

  logic            par_body_q, par_body_d;
  logic [3:0]      par_idx_q, par_idx_d;
  logic [9:0]      led_sh_q, led_sh_d, leds_q, leds_d;
  logic [4:0][6:0] hex_sh_q, hex_sh_d;
  logic [5:0][6:0] hex_q, hex_d;
  logic            valid_q, valid_d, err_q, err_d;

`ifdef LAB_HOST_LINK_AUTOSEND_EN
  // snap_q holds the last transmitted state, so any difference means unsent changes
  assign send_req = i_SEND || ({i_BUTTON, i_SWITCH} != snap_q);
`else
  assign send_req = i_SEND;
`endif

  assign tx_tick = (tx_cnt_q == BIT_LAST);
  assign tx_data = (tx_byte_q == 2'd0) ? 8'hA5 :
                   (tx_byte_q == 2'd1) ? snap_q[7:0] : {snap_q[13:10], 2'b00, snap_q[9:8]};

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      snap_q     <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      snap_q     <= snap_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    snap_d     = snap_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        if (send_req) begin
          snap_d     = {i_BUTTON, i_SWITCH};
          tx_byte_d  = 2'd0;
          tx_state_d = T_START;
        end
      end
      T_START: if (tx_tick) begin
        tx_bit_d   = 3'd0;
        tx_state_d = T_DATA;
      end
      T_DATA: if (tx_tick) begin
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
      end
      default: if (tx_tick) begin
        // bytes run back to back: STOP goes straight to the next START
        tx_byte_d  = tx_byte_q + 2'd1;
        tx_state_d = (tx_byte_q == 2'd2) ? T_IDLE : T_START;
      end
    endcase
  end

  always_comb begin
    o_BUSY = (tx_state_q != T_IDLE);
    case (tx_state_q)
      T_START: o_TX = 1'b0;
      T_DATA:  o_TX = tx_data[tx_bit_q];
      default: o_TX = 1'b1;
    endcase
  end

  assign rx_tick = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      par_body_q <= 1'b0;
      par_idx_q  <= '0;
      led_sh_q   <= '0;
      hex_sh_q   <= '0;
      leds_q     <= '0;
      hex_q      <= {6{7'h7F}};
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_s1_q    <= i_RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      par_body_q <= par_body_d;
      par_idx_q  <= par_idx_d;
      led_sh_q   <= led_sh_d;
      hex_sh_q   <= hex_sh_d;
      leds_q     <= leds_d;
      hex_q      <= hex_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_ok    = 1'b0;
    byte_bad   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end
      default: if (rx_tick) begin
        rx_cnt_d   = '0;
        byte_ok    = rx_s2_q;
        byte_bad   = !rx_s2_q;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // Frame parser: body bytes go to shadows; byte 8 commits everything in one edge
  always_comb begin
    par_body_d = par_body_q;
    par_idx_d  = par_idx_q;
    led_sh_d   = led_sh_q;
    hex_sh_d   = hex_sh_q;
    leds_d     = leds_q;
    hex_d      = hex_q;
    valid_d    = 1'b0;
    err_d      = byte_bad;
    if (byte_bad) begin
      par_body_d = 1'b0;
    end else if (byte_ok) begin
      if (!par_body_q) begin
        par_body_d = (rx_sh_q == 8'h5A);
        par_idx_d  = 4'd1;
      end else begin
        par_idx_d = par_idx_q + 4'd1;
        case (par_idx_q)
          4'd1: led_sh_d[7:0] = rx_sh_q;
          4'd2: led_sh_d[9:8] = rx_sh_q[1:0];
          4'd8: begin
            leds_d     = led_sh_q;
            hex_d      = {rx_sh_q[6:0], hex_sh_q};
            valid_d    = 1'b1;
            par_body_d = 1'b0;
          end
          default: hex_sh_d[3'(par_idx_q - 4'd3)] = rx_sh_q[6:0];
        endcase
      end
    end
  end

  assign o_LEDS  = leds_q;
  assign o_7S0   = hex_q[0];
  assign o_7S1   = hex_q[1];
  assign o_7S2   = hex_q[2];
  assign o_7S3   = hex_q[3];
  assign o_7S4   = hex_q[4];
  assign o_7S5   = hex_q[5];
  assign o_VALID = valid_q;
  assign o_ERR   = err_q;
endmodule
